// File: rtl/mem_copy_pkg.sv
// Shared definitions for the memory copy engine: default bus widths and
// the copy sequencer state encoding.
package mem_copy_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } copy_state_t;

endpackage

// File: rtl/mem_copy_engine.sv
// Block-copy bus initiator for the data memory. Copies `length` bytes from
// srcAddr to dstAddr in ascending order, one READ cycle followed by one
// WRITE cycle per byte; both pointers wrap at the top of the address space.
// All bus outputs are decoded from registered state only.
// Optional build feature: define MEM_COPY_CHECKSUM_EN to add a `checksum`
// output holding the XOR of every byte written by the current/last copy.
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int ADDR_W = mem_copy_pkg::ADDR_W,
  parameter int DATA_W = mem_copy_pkg::DATA_W,
  parameter int LEN_W  = mem_copy_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] srcAddr,
  input  logic [ADDR_W-1:0] dstAddr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              memRead,
  output logic              memWrite,
  output logic [ADDR_W-1:0] memAddress,
  output logic [DATA_W-1:0] memWriteData,
  input  logic [DATA_W-1:0] memReadData
`ifdef MEM_COPY_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  copy_state_t       state_reg, state_next;
  logic [ADDR_W-1:0] src_ptr_reg, src_ptr_next;
  logic [ADDR_W-1:0] dst_ptr_reg, dst_ptr_next;
  logic [LEN_W-1:0]  remaining_reg, remaining_next;
  logic [DATA_W-1:0] hold_reg, hold_next;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_reg, checksum_next;

  assign checksum = checksum_reg;
`endif

  // Next-state, datapath updates and bus strobes decoded from the current state.
  always_comb begin
    state_next     = state_reg;
    src_ptr_next   = src_ptr_reg;
    dst_ptr_next   = dst_ptr_reg;
    remaining_next = remaining_reg;
    hold_next      = hold_reg;
`ifdef MEM_COPY_CHECKSUM_EN
    checksum_next  = checksum_reg;
`endif
    busy         = 1'b0;
    done         = 1'b0;
    memRead      = 1'b0;
    memWrite     = 1'b0;
    memAddress   = '0;
    memWriteData = '0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          src_ptr_next   = srcAddr;
          dst_ptr_next   = dstAddr;
          remaining_next = length;
`ifdef MEM_COPY_CHECKSUM_EN
          checksum_next  = '0;
`endif
          // A zero-length request still produces its done pulse.
          state_next = (length != '0) ? READ : DONE;
        end
      end
      READ: begin
        busy         = 1'b1;
        memRead      = 1'b1;
        memAddress   = src_ptr_reg;
        hold_next    = memReadData;
        src_ptr_next = src_ptr_reg + ADDR_W'(1);
        state_next   = WRITE;
      end
      WRITE: begin
        busy           = 1'b1;
        memWrite       = 1'b1;
        memAddress     = dst_ptr_reg;
        memWriteData   = hold_reg;
        dst_ptr_next   = dst_ptr_reg + ADDR_W'(1);
        remaining_next = remaining_reg - LEN_W'(1);
`ifdef MEM_COPY_CHECKSUM_EN
        checksum_next  = checksum_reg ^ hold_reg;
`endif
        state_next = (remaining_reg != LEN_W'(1)) ? READ : DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; reset aborts any copy in progress immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Pointer, byte counter, hold byte (and optional checksum) registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_ptr_reg   <= '0;
      dst_ptr_reg   <= '0;
      remaining_reg <= '0;
      hold_reg      <= '0;
`ifdef MEM_COPY_CHECKSUM_EN
      checksum_reg  <= '0;
`endif
    end else begin
      src_ptr_reg   <= src_ptr_next;
      dst_ptr_reg   <= dst_ptr_next;
      remaining_reg <= remaining_next;
      hold_reg      <= hold_next;
`ifdef MEM_COPY_CHECKSUM_EN
      checksum_reg  <= checksum_next;
`endif
    end
  end

endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
- Bus initiator for the 256 x 8 data memory: drives memRead/memWrite/address/writeData and samples readData.
- Performs block copies of up to 255 bytes from a source region to a destination region.
- Sits beside the CPU datapath. An external mux hands the memory port to this block while busy=1.
- Read/write timing matches the memory: read data is combinational in the same cycle as memRead; the write commits at the posedge with memWrite=1.

Parameters:
- ADDR_W, 8, memory address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 8, data word width.
- LEN_W, 8, width of the length field; lengths range 0..2^LEN_W-1.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- srcAddr  input  ADDR_W  first source address.
- dstAddr  input  ADDR_W  first destination address.
- length  input  LEN_W  number of bytes to copy.
- busy  output  1  high from the cycle after accepted start until done; memory-bus ownership flag.
- done  output  1  one-cycle completion pulse.
- memRead  output  1  read strobe to memory.
- memWrite  output  1  write strobe to memory.
- memAddress  output  ADDR_W  memory address.
- memWriteData  output  DATA_W  memory write data.
- memReadData  input  DATA_W  combinational read data from memory.

Behaviour:
- Reset values (asynchronous): state=IDLE; busy, done, memRead, memWrite = 0; memAddress, memWriteData = 0; internal src/dst pointers, count and hold register = 0.
- States:
  - IDLE: all strobes 0. On start=1, latch srcAddr, dstAddr, length into srcPtr, dstPtr, remaining. Go to READ if length!=0, else DONE.
  - READ: memRead=1, memAddress=srcPtr. At the posedge, hold<=memReadData, srcPtr<=srcPtr+1 (wraps 0xFF->0x00). Go to WRITE.
  - WRITE: memWrite=1, memAddress=dstPtr, memWriteData=hold. At the posedge, dstPtr<=dstPtr+1 (wraps), remaining<=remaining-1. Go to READ if remaining!=1, else DONE.
  - DONE: done=1 for exactly this cycle; busy=0. Go to IDLE.
- busy=1 exactly in the READ and WRITE states. memRead and memWrite are never both 1.
- Latency: length L>0 gives 2L busy cycles, with done in cycle 2L+1 after acceptance. L=0 gives done in the cycle after acceptance, with no memory strobes.
- start while not in IDLE (including DONE) is ignored. Input changes after acceptance have no effect.
- Outputs are registered-state decodes only: no combinational path from start to the strobes.
- Copy order is always ascending and each byte is read immediately before it is written. An overlapping copy with dst=src+k (0<k<L) therefore replicates the first k bytes; this is intended behaviour.
- Address wrap: a region crossing 0xFF continues at 0x00 for both source and destination.
- Reset mid-operation: immediate return to IDLE. Writes already committed stay in memory; no further strobes; no done pulse.

Optional Feature:
- Macro: MEM_COPY_CHECKSUM_EN.
- Defined:
  - Adds output checksum (DATA_W): XOR of every byte written in the current copy.
  - Cleared on accepted start; updated at each WRITE posedge with hold; holds its value after done until the next accepted start; reset to 0.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package mem_copy_pkg:
  - ADDR_W, DATA_W, LEN_W defaults.
  - State enum copy_state_t {IDLE, READ, WRITE, DONE}, 2-bit encoding.
- Single module; no sub-module is warranted. The FSM and the three counters are tightly coupled.

Test Plan:
- Memory preloaded 0x10..0x13 = A1 B2 C3 D4; start src=0x10 dst=0x80 len=4 -> busy 8 cycles, strobes alternate R/W, 0x80..0x83 = A1 B2 C3 D4, done one cycle; checksum=0x04 with MEM_COPY_CHECKSUM_EN.
- len=0, src=0x20, dst=0x40 -> done in the cycle after start; memRead and memWrite never asserted; memory unchanged.
- src=0xFE dst=0x01 len=3, memory FE=11 FF=22 00=33 -> 0x01=11, 0x02=22, 0x03=33; source address sequence FE, FF, 00.
- Overlap: 0x50=5A, 0x51=6B, start src=0x50 dst=0x51 len=3 -> 0x51..0x53 all = 5A.
- start re-pulsed while busy with different args -> ignored; original copy completes unchanged; exactly one done pulse.
- reset asserted after the 2nd WRITE of a len=5 copy -> strobes drop asynchronously; only 2 destination bytes changed; no done; next start runs normally.
